// File: rtl/spi_flash_master_seq_if.sv
// Bus bundle for the SPI flash master: CPU-side request/response plus flash pins.
interface spi_flash_master_seq_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 24,
   parameter int CMD_W   = 8,
   parameter int DUMMY_W = 5
) ();
   localparam int BITS_W = $clog2(DATA_W + 1);

   logic                cmd_valid;
   logic                cmd_ready;
   logic [CMD_W-1:0]    cmd;
   logic [ADDR_W-1:0]   addr;
   logic                addr_en;
   logic [DUMMY_W-1:0]  dummy_cycles;
   logic [DATA_W-1:0]   tx_data;
   logic [BITS_W-1:0]   tx_bits;
   logic [BITS_W-1:0]   rx_bits;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_data;
   logic                busy;
   logic                sclk;
   logic                ss_n;
   logic                mosi;
   logic                miso;

   modport master (
      input  cmd_valid, cmd, addr, addr_en, dummy_cycles, tx_data, tx_bits, rx_bits,
      input  rsp_ready, miso,
      output cmd_ready, rsp_valid, rsp_data, busy, sclk, ss_n, mosi
   );

   modport slave (
      output cmd_valid, cmd, addr, addr_en, dummy_cycles, tx_data, tx_bits, rx_bits,
      output rsp_ready, miso,
      input  cmd_ready, rsp_valid, rsp_data, busy, sclk, ss_n, mosi
   );
endinterface

// File: rtl/spi_flash_master_seq.sv
// SPI mode-0 flash master: one framed transaction (cmd/addr/dummy/tx/rx) per request.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | ss_n high, waiting for a request (and for any response to drain)
//  S_CMD   | shifting out the opcode
//  S_ADDR  | shifting out the address
//  S_DUMMY | dummy sclk cycles, mosi held low
//  S_TX    | shifting out the write payload
//  S_RX    | sampling miso into the response shifter
//  S_HOLD  | sclk low for one half-period before ss_n is released
//  S_GAP   | ss_n high for the minimum deselect time
module spi_flash_master_seq #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 24,
   parameter int CMD_W   = 8,
   parameter int DUMMY_W = 5,
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 4
) (
   input logic                    clk,
   input logic                    rst,
   spi_flash_master_seq_if.master bus
);
   localparam int BITS_W    = $clog2(DATA_W + 1);
   localparam int MAX_AD    = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam int SH_W      = (MAX_AD > CMD_W) ? MAX_AD : CMD_W;
   localparam int DUMMY_MAX = 1 << DUMMY_W;
   localparam int CNT_MAX   = (SH_W > DUMMY_MAX) ? SH_W : DUMMY_MAX;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int DIV_W     = $clog2(CLK_DIV + 1);
   localparam int GAP_LD    = (CS_GAP < 1) ? 1 : CS_GAP;
   localparam int GAP_W     = $clog2(GAP_LD + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_TX, S_RX, S_HOLD, S_GAP
   } state_t;

   state_t              state_q, state_d, nxt;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, ld_cnt;
   logic [SH_W-1:0]     sh_q, sh_d, ld_sh;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                sclk_q, sclk_d;
   logic                ss_n_q, ss_n_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                addr_en_q, addr_en_d;
   logic [DUMMY_W-1:0]  dummy_q, dummy_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   txd_q, txd_d;
   logic [BITS_W-1:0]   txb_q, txb_d;
   logic [BITS_W-1:0]   rxb_q, rxb_d;
   logic                cmd_ready;
   logic                tick;

   assign cmd_ready     = (state_q == S_IDLE) && !rsp_valid_q;
   assign bus.cmd_ready = cmd_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.sclk      = sclk_q;
   assign bus.ss_n      = ss_n_q;
   // mosi is the shifter MSB; the shifter is cleared outside data-bearing phases
   assign bus.mosi      = sh_q[SH_W-1];

   // State and datapath registers, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         gap_q       <= '0;
         cnt_q       <= '0;
         sh_q        <= '0;
         rx_q        <= '0;
         sclk_q      <= 1'b0;
         ss_n_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         addr_en_q   <= 1'b0;
         dummy_q     <= '0;
         addr_q      <= '0;
         txd_q       <= '0;
         txb_q       <= '0;
         rxb_q       <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         gap_q       <= gap_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         rx_q        <= rx_d;
         sclk_q      <= sclk_d;
         ss_n_q      <= ss_n_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         addr_en_q   <= addr_en_d;
         dummy_q     <= dummy_d;
         addr_q      <= addr_d;
         txd_q       <= txd_d;
         txb_q       <= txb_d;
         rxb_q       <= rxb_d;
      end
   end

   // Next-state: phase sequencing, sclk divider, bit shifting and response handshake
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      gap_d       = gap_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      rx_d        = rx_q;
      sclk_d      = sclk_q;
      ss_n_d      = ss_n_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      addr_en_d   = addr_en_q;
      dummy_d     = dummy_q;
      addr_d      = addr_q;
      txd_d       = txd_q;
      txb_d       = txb_q;
      rxb_d       = rxb_q;
      tick        = (div_q == DIV_W'(1));

      // Earliest non-empty phase after the current one; later checks override earlier ones
      nxt = S_HOLD;
      if (rxb_q != '0 && state_q != S_RX) nxt = S_RX;
      if (txb_q != '0 && state_q inside {S_CMD, S_ADDR, S_DUMMY}) nxt = S_TX;
      if (dummy_q != '0 && state_q inside {S_CMD, S_ADDR}) nxt = S_DUMMY;
      if (addr_en_q && state_q == S_CMD) nxt = S_ADDR;

      ld_sh  = '0;
      ld_cnt = '0;
      case (nxt)
         S_ADDR: begin
            ld_sh  = SH_W'(addr_q) << (SH_W - ADDR_W);
            ld_cnt = CNT_W'(ADDR_W);
         end
         S_DUMMY: ld_cnt = CNT_W'(dummy_q);
         S_TX: begin
            ld_sh  = SH_W'(txd_q) << (SH_W - DATA_W);
            ld_cnt = CNT_W'(txb_q);
         end
         S_RX:    ld_cnt = CNT_W'(rxb_q);
         default: ;
      endcase

      if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               state_d   = S_CMD;
               ss_n_d    = 1'b0;
               sh_d      = SH_W'(bus.cmd) << (SH_W - CMD_W);
               cnt_d     = CNT_W'(CMD_W);
               div_d     = DIV_W'(CLK_DIV);
               rx_d      = '0;
               addr_en_d = bus.addr_en;
               dummy_d   = bus.dummy_cycles;
               addr_d    = bus.addr;
               txd_d     = bus.tx_data;
               txb_d     = (bus.tx_bits > BITS_W'(DATA_W)) ? BITS_W'(DATA_W) : bus.tx_bits;
               rxb_d     = (bus.rx_bits > BITS_W'(DATA_W)) ? BITS_W'(DATA_W) : bus.rx_bits;
            end
         end
         S_CMD, S_ADDR, S_DUMMY, S_TX, S_RX: begin
            div_d = tick ? DIV_W'(CLK_DIV) : div_q - DIV_W'(1);
            if (tick) begin
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  if (state_q == S_RX) rx_d = {rx_q[DATA_W-2:0], bus.miso};
               end else if (cnt_q == CNT_W'(1)) begin
                  state_d = nxt;
                  cnt_d   = ld_cnt;
                  sh_d    = ld_sh;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  sh_d  = sh_q << 1;
               end
            end
         end
         S_HOLD: begin
            div_d = tick ? DIV_W'(CLK_DIV) : div_q - DIV_W'(1);
            if (tick) begin
               state_d = S_GAP;
               ss_n_d  = 1'b1;
               gap_d   = GAP_W'(GAP_LD);
               if (rxb_q != '0) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = rx_q;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q == GAP_W'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_spi_flash_master_seq.sv
// Bench for spi_flash_master_seq: bit-list reference model with a serial flash responder.
module tb_spi_flash_master_seq;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 24;
   localparam int CMD_W   = 8;
   localparam int DUMMY_W = 5;
   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 4;
   localparam int TCLK    = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #(TCLK/2) clk = ~clk;

   int total = 0;
   int bad   = 0;

   spi_flash_master_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .DUMMY_W(DUMMY_W)) bus ();

   spi_flash_master_seq #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .DUMMY_W(DUMMY_W),
      .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
   ) dut (.clk(clk), .rst(rst), .bus(bus.master));

   // ---------------- flash responder and pin monitor for the main DUT ----------------
   int          rises = 0;
   int          tbad  = 0;
   int          hs    = 0;
   logic [31:0] hs_data = '0;
   time         t_fall_ss = 0, t_rise_ss = 0, t_last_rise = 0, t_last_fall = 0;
   bit          mosi_seen[$];
   int          m_rx_start = 0;
   int          m_rxb = 0;
   logic [31:0] m_resp = '0;

   function automatic logic miso_bit(input int k);
      if (k >= m_rx_start && k < m_rx_start + m_rxb) return m_resp[m_rxb - 1 - (k - m_rx_start)];
      return 1'b0;
   endfunction

   always @(negedge bus.ss_n) begin
      if (!rst && ($time - t_rise_ss) < CS_GAP * TCLK) tbad++;
      rises = 0;
      mosi_seen.delete();
      t_fall_ss = $time;
      bus.miso = miso_bit(0);
   end

   always @(posedge bus.sclk) begin
      if (!rst) begin
         if (rises == 0) begin
            if ($time - t_fall_ss != CLK_DIV * TCLK) tbad++;
         end else if ($time - t_last_rise != 2 * CLK_DIV * TCLK) tbad++;
         t_last_rise = $time;
         mosi_seen.push_back(bus.mosi);
         rises++;
         bus.miso = miso_bit(rises);
      end
   end

   always @(negedge bus.sclk) begin
      if (!rst) begin
         if ($time - t_last_rise != CLK_DIV * TCLK) tbad++;
         t_last_fall = $time;
      end
   end

   always @(posedge bus.ss_n) begin
      if (!rst && rises > 0 && ($time - t_last_fall != CLK_DIV * TCLK)) tbad++;
      t_rise_ss = $time;
   end

   always @(negedge clk) begin
      if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         hs++;
         hs_data = bus.rsp_data;
      end
   end

   // ---------------- CLK_DIV=1 and CLK_DIV=4 instances running Read ID ----------------
   logic [1:0] x_valid = 2'b00;

   for (genvar g = 0; g < 2; g++) begin : g_x
      localparam int DIV = (g == 0) ? 1 : 4;
      spi_flash_master_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .DUMMY_W(DUMMY_W)) xb ();
      spi_flash_master_seq #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .DUMMY_W(DUMMY_W),
         .CLK_DIV(DIV), .CS_GAP(CS_GAP)
      ) u_x (.clk(clk), .rst(rst), .bus(xb.master));

      assign xb.cmd_valid    = x_valid[g];
      assign xb.cmd          = 8'h9F;
      assign xb.addr         = '0;
      assign xb.addr_en      = 1'b0;
      assign xb.dummy_cycles = '0;
      assign xb.tx_data      = '0;
      assign xb.tx_bits      = '0;
      assign xb.rx_bits      = 6'd24;
      assign xb.rsp_ready    = 1'b1;

      int          rises = 0;
      int          tbad  = 0;
      int          hs    = 0;
      logic [31:0] cap   = '0;
      logic [23:0] id_v  = 24'hEF4018;
      time         tr = 0, tf = 0;

      always @(negedge xb.ss_n) begin
         rises   = 0;
         tf      = $time;
         xb.miso = 1'b0;
      end
      always @(posedge xb.sclk) begin
         if (!rst) begin
            if (rises == 0) begin
               if ($time - tf != DIV * TCLK) tbad++;
            end else if ($time - tr != 2 * DIV * TCLK) tbad++;
            tr = $time;
            rises++;
            xb.miso = (rises >= 8 && rises < 32) ? id_v[31 - rises] : 1'b0;
         end
      end
      always @(negedge xb.sclk) begin
         if (!rst && ($time - tr != DIV * TCLK)) tbad++;
      end
      always @(negedge clk) begin
         if (!rst && xb.rsp_valid === 1'b1) begin
            hs++;
            cap = xb.rsp_data;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input string tag, input logic [7:0] c, input logic ae,
                            input logic [23:0] a, input logic [4:0] dm, input logic [31:0] td,
                            input int txb, input int rxb, input logic [31:0] resp, input int stall);
      bit          exp_bits[$];
      int          tbc, rbc, n_exp, hs0, tbad0, n, mis, sbad;
      logic [31:0] exp_rsp, held;
      tbc = (txb > DATA_W) ? DATA_W : txb;
      rbc = (rxb > DATA_W) ? DATA_W : rxb;
      for (int i = 0; i < CMD_W; i++) exp_bits.push_back(c[CMD_W-1-i]);
      if (ae) for (int i = 0; i < ADDR_W; i++) exp_bits.push_back(a[ADDR_W-1-i]);
      for (int i = 0; i < int'(dm); i++) exp_bits.push_back(1'b0);
      for (int i = 0; i < tbc; i++) exp_bits.push_back(td[DATA_W-1-i]);
      for (int i = 0; i < rbc; i++) exp_bits.push_back(1'b0);
      n_exp   = exp_bits.size();
      exp_rsp = (rbc == 32) ? resp : (resp & ((32'd1 << rbc) - 32'd1));
      m_rx_start = n_exp - rbc;
      m_rxb      = rbc;
      m_resp     = resp;
      hs0   = hs;
      tbad0 = tbad;

      @(negedge clk);
      bus.cmd          = c;
      bus.addr_en      = ae;
      bus.addr         = a;
      bus.dummy_cycles = dm;
      bus.tx_data      = td;
      bus.tx_bits      = 6'(txb);
      bus.rx_bits      = 6'(rxb);
      bus.rsp_ready    = (stall == 0);
      bus.cmd_valid    = 1'b1;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      check({tag, "_accept"}, n < 2000, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check({tag, "_start"}, {bus.ss_n, bus.mosi, bus.busy, bus.cmd_ready}, {1'b0, c[7], 1'b1, 1'b0});

      n = 0;
      while (bus.ss_n !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      check({tag, "_end"}, n < 2000, 1'b1);
      check({tag, "_rsp_valid"}, bus.rsp_valid, rbc > 0);
      if (rbc > 0) check({tag, "_rsp_data"}, bus.rsp_data, exp_rsp);

      if (stall > 0) begin
         held = bus.rsp_data;
         sbad = 0;
         repeat (stall) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.cmd_ready !== 1'b0) sbad++;
         end
         check({tag, "_stall_stable"}, sbad, 0);
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         check({tag, "_after_hs"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
      end

      n = 0;
      while (bus.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      check({tag, "_idle"}, n < 100, 1'b1);
      @(negedge clk);

      mis = 0;
      for (int i = 0; i < n_exp; i++)
         if (i >= mosi_seen.size() || mosi_seen[i] !== exp_bits[i]) mis++;
      check({tag, "_rises"}, rises, n_exp);
      check({tag, "_mosi_bits"}, mis, 0);
      check({tag, "_hs_count"}, hs - hs0, (rbc > 0) ? 1 : 0);
      if (rbc > 0) check({tag, "_hs_data"}, hs_data, exp_rsp);
      check({tag, "_timing"}, tbad - tbad0, 0);
   endtask

   initial begin
      #(TCLK * 50000);
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hs_r;
      bus.cmd_valid = 1'b0; bus.cmd = '0; bus.addr = '0; bus.addr_en = 1'b0;
      bus.dummy_cycles = '0; bus.tx_data = '0; bus.tx_bits = '0; bus.rx_bits = '0;
      bus.rsp_ready = 1'b1; bus.miso = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {bus.cmd_ready, bus.rsp_valid, bus.busy}, 3'b100);
      check("reset_pins", {bus.sclk, bus.ss_n, bus.mosi}, 3'b010);
      check("reset_data", bus.rsp_data, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_frame("rdid",  8'h9F, 1'b0, 24'h0,      5'd0, 32'h0,        0,  24, 32'h00EF4018, 0);
      run_frame("fread", 8'h0B, 1'b1, 24'h001000, 5'd8, 32'h0,        0,  32, 32'hDEADBEEF, 0);
      run_frame("pp",    8'h02, 1'b1, 24'h000100, 5'd0, 32'hA5A51234, 32, 0,  32'h0,        0);
      run_frame("bp",    8'h9F, 1'b0, 24'h0,      5'd0, 32'h0,        0,  24, 32'h00EF4018, 10);
      run_frame("clamp", 8'h3B, 1'b0, 24'h0,      5'd2, $urandom,     40, 45, $urandom,     0);
      run_frame("cmd_only", 8'h06, 1'b0, 24'h0,   5'd0, 32'h0,        0,  0,  32'h0,        0);

      // abort a frame in the middle of its address phase
      hs_r = hs;
      m_rx_start = 32; m_rxb = 16; m_resp = 32'h1234;
      @(negedge clk);
      bus.cmd = 8'h03; bus.addr_en = 1'b1; bus.addr = 24'hABCDEF; bus.dummy_cycles = '0;
      bus.tx_bits = '0; bus.rx_bits = 6'd16; bus.rsp_ready = 1'b1; bus.cmd_valid = 1'b1;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n = 0;
      while (rises < 12 && n < 500) begin @(negedge clk); n++; end
      check("rst_reach_addr", n < 500, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_async_pins", {bus.ss_n, bus.sclk, bus.mosi, bus.busy, bus.rsp_valid}, 5'b10000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_ready", bus.cmd_ready, 1'b1);
      repeat (8) @(negedge clk);
      check("rst_no_rsp", {hs - hs_r, 31'(0), bus.rsp_valid}, {32'(0), 31'(0), 1'b0});
      run_frame("post_rst", 8'h9F, 1'b0, 24'h0, 5'd0, 32'h0, 0, 24, 32'h00EF4018, 0);

      for (int i = 0; i < 8; i++) begin
         run_frame($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom_range(0, 1)), 24'($urandom),
                   5'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 36)),
                   int'($urandom_range(0, 36)), $urandom, 0);
      end

      // Read ID on the CLK_DIV=1 and CLK_DIV=4 instances
      @(negedge clk);
      check("xdiv_ready", {g_x[0].xb.cmd_ready, g_x[1].xb.cmd_ready}, 2'b11);
      x_valid = 2'b11;
      @(negedge clk);
      x_valid = 2'b00;
      n = 0;
      while ((g_x[0].hs < 1 || g_x[1].hs < 1) && n < 2000) begin @(negedge clk); n++; end
      repeat (10) @(negedge clk);
      check("div1_rises", g_x[0].rises, 32);
      check("div1_data",  g_x[0].cap, 32'h00EF4018);
      check("div1_hs",    g_x[0].hs, 1);
      check("div1_timing", g_x[0].tbad, 0);
      check("div4_rises", g_x[1].rises, 32);
      check("div4_data",  g_x[1].cap, 32'h00EF4018);
      check("div4_hs",    g_x[1].hs, 1);
      check("div4_timing", g_x[1].tbad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
